ppu_fb_writer: RTL and testbench
================================

// Module: ppu_fb_writer
// PURPOSE
//  Downstream consumer of the PPU pixel stream: takes 2-bit colour indices (PX_OUT/PX_valid),
//  maps them through BGP to 2-bit shades, packs 4 shades/byte and writes a 160x144 2bpp
//  framebuffer RAM. Tracks x/y from PPU_MODE edges; ping-pong banks so the video-out side
//  always reads a complete frame.
// PARAMETERS
//  H_PIXELS    160  visible pixels per line; excess pixels on a line are dropped
//  V_LINES     144  visible lines per frame
//  DOUBLE_BUF  1    1 = two banks, toggled per frame; 0 = single bank, FB_ADDR[13] = 0
// PORTS
//  clk         in   1   system clock, single domain
//  rst         in   1   asynchronous, active-high reset
//  LCD_EN      in   1   LCDC[7]; low aborts current frame
//  PPU_MODE    in   2   0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//  PX_IN       in   2   colour index from PPU shifter, bit1 = high plane
//  PX_valid    in   1   PX_IN valid this cycle (only honoured in DRAW)
//  BGP         in   8   palette; shade(i) = BGP[2i+1:2i]
//  FB_WE       out  1   framebuffer write strobe, one cycle per byte
//  FB_ADDR     out  14  {bank, y*40 + x/4}; 5760 bytes per bank
//  FB_DATA     out  8   packed shades, first pixel in [7:6], fourth in [1:0]
//  DISP_BANK   out  1   bank holding the last completed frame (read side)
//  LINE_DONE   out  1   1-cycle pulse when a line is committed
//  FRAME_DONE  out  1   1-cycle pulse when line V_LINES-1 is committed
//  OVERFLOW    out  1   sticky: pixel arrived with x == H_PIXELS; cleared by reset only
// BEHAVIOUR
//  Reset: FB_WE=0, FB_ADDR=0, FB_DATA=0, DISP_BANK=1, LINE_DONE=0, FRAME_DONE=0,
//   OVERFLOW=0; x=0, y=0, pack count=0, write bank=0, state IDLE.
//  States: IDLE -> ACTIVE on PPU_MODE==DRAW; ACTIVE -> FLUSH on DRAW->non-DRAW edge;
//   FLUSH -> COMMIT (1 cycle) -> IDLE. V_BLANK in IDLE holds; y forced to 0 on V_BLANK entry.
//  ACTIVE: each PX_valid with x<H_PIXELS: shade latched into pack[3-x%4]; x++.
//   On 4th pixel of a group: next cycle FB_WE=1, FB_DATA=packed, FB_ADDR={bank,y*40+(x-4)/4}.
//   Latency pixel-4-accepted -> FB_WE = 1 cycle. x>=H_PIXELS: pixel dropped, OVERFLOW set.
//  FLUSH: if x%4 != 0, one write of the partial byte, unfilled slots = 2'b00; else no write.
//   4th pixel in the same cycle as the DRAW exit: accepted, full byte written, no extra flush.
//  COMMIT: LINE_DONE=1; x=0; if y==V_LINES-1: FRAME_DONE=1, y=0, DISP_BANK<=write bank,
//   write bank toggles (DOUBLE_BUF=1 only); else y++.
//  Short line (<H_PIXELS pixels): remaining bytes not written; line still committed.
//  BGP sampled per pixel at acceptance; mid-line writes take effect on next pixel.
//  LCD_EN low (any state): abort to IDLE, x=y=0, pack cleared, no write, no pulses, banks and
//   DISP_BANK unchanged. rst mid-write: async clear, the in-flight write is dropped.
//  y*40 computed as (y<<5)+(y<<3); all address arithmetic 13-bit unsigned, no wrap reachable.
// STRUCTURE
//  ppu_pkg: PPU_MODE_t enum (H_BLANK, V_BLANK, SCAN, DRAW), FBW_STATE_t enum,
//   localparams H_PIXELS_DEF, V_LINES_DEF, BYTES_PER_LINE=40; shared with the PPU.
//  Sub-module ppu_px_packer: palette map + 4:1 shift/pack + count, emits byte_valid/byte/partial.
//  Top holds FSM, x/y counters, bank control, address generation.
// TESTING
//  1 BGP=8'hE4, line 0 pixels 0,1,2,3 -> FB_WE once, FB_ADDR=0, FB_DATA=8'h1B, 1 cycle later.
//  2 BGP=8'h1B, PX_IN=3 x160 on line 5 -> 40 writes of 8'h00, FB_ADDR 200..239, LINE_DONE once.
//  3 162 valid pixels on a line -> 40 writes, OVERFLOW=1, remains 1 until rst.
//  4 6 pixels idx 1 (BGP=E4) then DRAW exit -> writes 8'h55 then 8'h50 (flush), LINE_DONE.
//  5 144 full lines -> FRAME_DONE once after line 143, DISP_BANK 1->0, next write FB_ADDR[13]=1.
//  6 LCD_EN low mid-line 10 at x=37 -> no write, no pulses; next DRAW starts y=0, FB_ADDR low=0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode/state encodings, frame geometry and small helpers
// used by both the PPU core and the framebuffer writer.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_MODE_t;

    typedef enum logic [1:0] {
        FBW_IDLE   = 2'd0,
        FBW_ACTIVE = 2'd1,
        FBW_FLUSH  = 2'd2,
        FBW_COMMIT = 2'd3
    } FBW_STATE_t;

    localparam int H_PIXELS_DEF   = 160;
    localparam int V_LINES_DEF    = 144;
    localparam int BYTES_PER_LINE = 40;

    // Palette lookup: shade(i) = bgp[2i+1:2i]
    function automatic logic [1:0] bgp_shade(input logic [7:0] bgp, input logic [1:0] idx);
        return bgp[{idx, 1'b0} +: 2];
    endfunction

    // Byte offset of the start of line y: y*40 built from two shifts (y*32 + y*8)
    function automatic logic [12:0] line_base(input logic [7:0] y);
        return ({5'd0, y} << 5) + ({5'd0, y} << 3);
    endfunction

endpackage

// File: rtl/ppu_px_packer.sv
// Palette-maps incoming colour indices and packs four 2-bit shades per byte.
// First pixel of a group lands in [7:6]; a flush emits a partially filled byte
// with the empty slots left at 2'b00.
module ppu_px_packer
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       px_accept,
    input  logic [1:0] px_idx,
    input  logic [7:0] bgp,
    input  logic       flush,
    output logic       partial,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic [1:0] count;
    logic [7:0] pack;
    logic [7:0] pack_next;
    logic [1:0] shade;

    assign partial = (count != 2'd0);

    // Merge the shade of the current pixel into slot 3-count of the pack
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch
        shade     = bgp_shade(bgp, px_idx);
        pack_next = pack;
        pack_next[{~count, 1'b0} +: 2] = shade;
    end

    // Pack register, slot counter and the byte strobe to the framebuffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            pack       <= 8'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values
            byte_valid <= 1'b0;
            if (clear) begin
                count <= 2'd0;
                pack  <= 8'd0;
            end else if (px_accept) begin
                count <= count + 2'd1;
                if (count == 2'd3) begin
                    byte_valid <= 1'b1;
                    byte_data  <= pack_next;
                    pack       <= 8'd0;
                end else begin
                    pack <= pack_next;
                end
            end else if (flush && partial) begin
                byte_valid <= 1'b1;
                byte_data  <= pack;
                pack       <= 8'd0;
                count      <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/ppu_fb_writer.sv
// Framebuffer writer: follows PPU_MODE to track the pixel position, drives the
// packer, generates byte addresses and flips ping-pong banks once per frame so
// the display side always reads a finished frame.
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter bit DOUBLE_BUF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LCD_EN,
    input  logic [1:0]  PPU_MODE,
    input  logic [1:0]  PX_IN,
    input  logic        PX_valid,
    input  logic [7:0]  BGP,
    output logic        FB_WE,
    output logic [13:0] FB_ADDR,
    output logic [7:0]  FB_DATA,
    output logic        DISP_BANK,
    output logic        LINE_DONE,
    output logic        FRAME_DONE,
    output logic        OVERFLOW
);

    localparam logic [7:0] X_MAX  = 8'(H_PIXELS);
    localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

    FBW_STATE_t  state;
    PPU_MODE_t   mode;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        wr_bank;
    logic        in_draw;
    logic        x_full;
    logic        px_accept;
    logic        flush;
    logic        partial;
    logic [12:0] byte_addr;

    assign mode      = PPU_MODE_t'(PPU_MODE);
    assign in_draw   = (mode == DRAW);
    assign x_full    = (x >= X_MAX);
    assign px_accept = LCD_EN && (state == FBW_ACTIVE) && in_draw && PX_valid && !x_full;
    assign flush     = LCD_EN && (state == FBW_FLUSH);
    // Byte holding pixel x of line y; valid both for a full group (x before
    // increment) and for a flush (x after the last partial pixel)
    assign byte_addr = line_base(y) + {7'd0, x[7:2]};

    ppu_px_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (!LCD_EN),
        .px_accept  (px_accept),
        .px_idx     (PX_IN),
        .bgp        (BGP),
        .flush      (flush),
        .partial    (partial),
        .byte_valid (FB_WE),
        .byte_data  (FB_DATA)
    );

    // Line/frame FSM with x/y tracking, address capture, bank control and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FBW_IDLE;
            x          <= 8'd0;
            y          <= 8'd0;
            wr_bank    <= 1'b0;
            DISP_BANK  <= 1'b1;
            FB_ADDR    <= 14'd0;
            LINE_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            LINE_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;

            if (LCD_EN && (state == FBW_ACTIVE) && in_draw && PX_valid && x_full)
                OVERFLOW <= 1'b1;

            if (!LCD_EN) begin
                // Abort: drop the line, keep banks and the display side untouched
                state <= FBW_IDLE;
                x     <= 8'd0;
                y     <= 8'd0;
            end else begin
                case (state)
                    FBW_IDLE: begin
                        if (mode == V_BLANK)
                            y <= 8'd0;
                        if (in_draw)
                            state <= FBW_ACTIVE;
                    end
                    FBW_ACTIVE: begin
                        if (!in_draw) begin
                            state <= FBW_FLUSH;
                        end else if (px_accept) begin
                            x <= x + 8'd1;
                            if (x[1:0] == 2'd3)
                                FB_ADDR <= {wr_bank, byte_addr};
                        end
                    end
                    FBW_FLUSH: begin
                        if (partial)
                            FB_ADDR <= {wr_bank, byte_addr};
                        state <= FBW_COMMIT;
                    end
                    FBW_COMMIT: begin
                        LINE_DONE <= 1'b1;
                        x         <= 8'd0;
                        state     <= FBW_IDLE;
                        if (y == Y_LAST) begin
                            FRAME_DONE <= 1'b1;
                            y          <= 8'd0;
                            DISP_BANK  <= wr_bank;
                            if (DOUBLE_BUF)
                                wr_bank <= ~wr_bank;
                        end else begin
                            y <= y + 8'd1;
                        end
                    end
                    default: state <= FBW_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Self-checking bench for ppu_fb_writer: randomized lines scored against a
// behavioural model of the framebuffer byte stream, line/frame counts and banks.
module tb_ppu_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        LCD_EN;
    logic [1:0]  PPU_MODE;
    logic [1:0]  PX_IN;
    logic        PX_valid;
    logic [7:0]  BGP;
    logic        FB_WE;
    logic [13:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        DISP_BANK;
    logic        LINE_DONE;
    logic        FRAME_DONE;
    logic        OVERFLOW;

    always #5 clk = ~clk;

    ppu_fb_writer dut (
        .clk        (clk),
        .rst        (rst),
        .LCD_EN     (LCD_EN),
        .PPU_MODE   (PPU_MODE),
        .PX_IN      (PX_IN),
        .PX_valid   (PX_valid),
        .BGP        (BGP),
        .FB_WE      (FB_WE),
        .FB_ADDR    (FB_ADDR),
        .FB_DATA    (FB_DATA),
        .DISP_BANK  (DISP_BANK),
        .LINE_DONE  (LINE_DONE),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW)
    );

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        int          cyc;   // expected observation cycle, -1 = not checked
    } wr_t;

    wr_t  exp_q[$];
    wr_t  e_mon;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   ld_seen = 0;
    int   fd_seen = 0;
    int   ld_exp  = 0;
    int   fd_exp  = 0;

    // Reference model state
    int         mx;
    int         my;
    logic       mbank;
    logic       mdisp;
    logic       movf;
    logic [7:0] mpack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: score every write and count pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (LINE_DONE)  ld_seen++;
            if (FRAME_DONE) fd_seen++;
            if (FB_WE) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write_addr", {18'd0, FB_ADDR}, 32'hFFFF_FFFF);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("fb_addr", {18'd0, FB_ADDR}, {18'd0, e_mon.addr});
                    check("fb_data", {24'd0, FB_DATA}, {24'd0, e_mon.data});
                    if (e_mon.cyc >= 0)
                        check("we_latency", cyc, e_mon.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DRAW cycle; the model applies the pixel rules to a valid pixel
    task automatic drive_px(input bit valid, input logic [1:0] idx, input logic [7:0] bgp);
        logic [1:0] shade;
        PPU_MODE = 2'd3;
        PX_valid = valid;
        PX_IN    = idx;
        BGP      = bgp;
        if (valid) begin
            if (mx < 160) begin
                shade = 2'(bgp >> (2 * idx));
                mpack = mpack | (8'(shade) << (6 - 2 * (mx % 4)));
                mx++;
                if (mx % 4 == 0) begin
                    exp_q.push_back('{addr: {mbank, 13'(my * 40 + (mx - 4) / 4)},
                                      data: mpack, cyc: cyc + 1});
                    mpack = 8'd0;
                end
            end else begin
                movf = 1'b1;
            end
        end
        tick();
    endtask

    task automatic end_line();
        PPU_MODE = 2'd0;
        PX_valid = 1'b0;
        if (mx % 4 != 0)
            exp_q.push_back('{addr: {mbank, 13'(my * 40 + mx / 4)}, data: mpack, cyc: -1});
        mpack = 8'd0;
        mx    = 0;
        ld_exp++;
        if (my == 143) begin
            fd_exp++;
            mdisp = mbank;
            mbank = ~mbank;
            my    = 0;
        end else begin
            my++;
        end
        repeat (6) tick();
        check("line_done_count", ld_seen, ld_exp);
        check("frame_done_count", fd_seen, fd_exp);
        check("disp_bank", {31'd0, DISP_BANK}, {31'd0, mdisp});
        check("overflow", {31'd0, OVERFLOW}, {31'd0, movf});
    endtask

    // idx_mode: -1 random, -2 sequential 0,1,2,3,..., otherwise fixed index
    task automatic do_line(input int n, input int idx_mode, input logic [7:0] bgp,
                           input bit rnd_bgp, input bit gaps);
        logic [1:0] idx;
        logic [7:0] b;
        PPU_MODE = 2'd3;
        PX_valid = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(7) == 0)
                drive_px(1'b0, 2'($urandom), 8'($urandom));
            idx = (idx_mode == -1) ? 2'($urandom) :
                  (idx_mode == -2) ? 2'(i % 4) : 2'(idx_mode);
            b   = rnd_bgp ? 8'($urandom) : bgp;
            drive_px(1'b1, idx, b);
        end
        end_line();
    endtask

    task automatic abort_line(input int n);
        int ld0;
        int fd0;
        PPU_MODE = 2'd3;
        PX_valid = 1'b0;
        tick();
        for (int i = 0; i < n; i++)
            drive_px(1'b1, 2'($urandom), 8'hE4);
        ld0 = ld_exp;
        fd0 = fd_exp;
        LCD_EN   = 1'b0;
        PX_valid = 1'b1;
        PX_IN    = 2'($urandom);
        mx    = 0;
        my    = 0;
        mpack = 8'd0;
        repeat (4) tick();
        LCD_EN   = 1'b1;
        PPU_MODE = 2'd0;
        PX_valid = 1'b0;
        repeat (4) tick();
        check("abort_line_done", ld_seen, ld0);
        check("abort_frame_done", fd_seen, fd0);
        check("abort_disp_bank", {31'd0, DISP_BANK}, {31'd0, mdisp});
        check("abort_overflow", {31'd0, OVERFLOW}, {31'd0, movf});
    endtask

    initial begin
        rst      = 1'b1;
        LCD_EN   = 1'b1;
        PPU_MODE = 2'd0;
        PX_IN    = 2'd0;
        PX_valid = 1'b0;
        BGP      = 8'hE4;
        mx = 0; my = 0; mbank = 1'b0; mdisp = 1'b1; movf = 1'b0; mpack = 8'd0;

        repeat (3) tick();
        check("rst_fb_we", {31'd0, FB_WE}, 32'd0);
        check("rst_fb_addr", {18'd0, FB_ADDR}, 32'd0);
        check("rst_fb_data", {24'd0, FB_DATA}, 32'd0);
        check("rst_disp_bank", {31'd0, DISP_BANK}, 32'd1);
        check("rst_line_done", {31'd0, LINE_DONE}, 32'd0);
        check("rst_frame_done", {31'd0, FRAME_DONE}, 32'd0);
        check("rst_overflow", {31'd0, OVERFLOW}, 32'd0);
        rst = 1'b0;
        tick();

        do_line(4, -2, 8'hE4, 1'b0, 1'b0);                          // y0: one byte 8'h1B at 0
        for (int l = 0; l < 4; l++)                                 // y1..y4: random short lines
            do_line($urandom_range(1, 160), -1, 8'h00, 1'b1, 1'b1);
        do_line(160, 3, 8'h1B, 1'b0, 1'b0);                         // y5: 40 bytes of 0 at 200..239
        do_line(162, -1, 8'hE4, 1'b0, 1'b1);                        // y6: overflow
        do_line(6, 1, 8'hE4, 1'b0, 1'b0);                           // y7: 8'h55 then flush 8'h50
        do_line(8, -1, 8'h00, 1'b1, 1'b1);                          // y8
        do_line(101, -1, 8'h00, 1'b1, 1'b1);                        // y9
        abort_line(37);                                             // y10 aborted at x=37

        do_line(20, -1, 8'h00, 1'b1, 1'b1);                         // y0 after abort
        do_line(33, -1, 8'h00, 1'b1, 1'b1);                         // y1
        PPU_MODE = 2'd1;                                            // V_BLANK returns y to 0
        my = 0;
        repeat (5) tick();
        PPU_MODE = 2'd0;
        tick();

        for (int l = 0; l < 144; l++)                               // full frame, bank flip
            do_line(160, -1, 8'h00, 1'b1, 1'b1);
        do_line(12, -1, 8'h00, 1'b1, 1'b0);                         // first line in bank 1

        repeat (4) tick();
        check("pending_writes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
